// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring
// divide, one bit per cycle, under a start/busy/done handshake with MTHI/MTLO.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        // Negation modulo 2^WIDTH keeps the most negative value as its unsigned magnitude.
        a_mag    = (op[0] && rs[WIDTH-1]) ? -rs : rs;
        b_mag    = (op[0] && rt[WIDTH-1]) ? -rt : rt;
        sum      = '0;
        shifted  = '0;
        trial    = '0;
        qbit     = 1'b0;
        prod     = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[1] && (rt == '0)) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                    end else begin
                        is_div_d = op[1];
                        qneg_d   = op[0] & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                        rneg_d   = op[0] & rs[WIDTH-1];
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        rem_d    = '0;
                        b_d      = b_mag;
                        cnt_d    = CW'(WIDTH);
                        state_d  = RUN;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end

            RUN: begin
                if (!is_div_q) begin
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    // Low half of acc holds the dividend, shifted out MSB-first and replaced by quotient bits.
                    shifted = {rem_q, acc_q[WIDTH-1]};
                    trial   = shifted - {1'b0, b_q};
                    qbit    = ~trial[WIDTH];
                    rem_d   = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc_d   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FIX;
            end

            FIX: begin
                if (!is_div_q) begin
                    prod = qneg_q ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    lo_d = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, handshake and
// reset sequences, and randomized ops against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs, rt, wdata;
    logic         hi_we, lo_we;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_hi, m_lo;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] rs;
        logic [W-1:0] rt;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dbz;
    } vec_t;

    vec_t vecs[$];

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-width products and truncating division on 64-bit integers.
    task automatic ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [63:0] tq, tr;
        eh = m_hi; el = m_lo; ed = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 0) ed = 1'b1;
                else begin el = a / b; eh = a % b; end
            end
            default: begin
                if (b == 0) ed = 1'b1;
                else begin
                    q = sa / sb; r = sa % sb;
                    tq = 64'(q); tr = 64'(r);
                    el = tq[31:0]; eh = tr[31:0];
                end
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic mt_write(input logic whi, input logic wlo, input logic [W-1:0] d);
        hi_we = whi; lo_we = wlo; wdata = d;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        if (whi) m_hi = d;
        if (wlo) m_lo = d;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    // Caller is #1 after an edge; start is sampled at the next edge (cycle 1 = that edge).
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic ed);
        int lat, bcnt;
        start = 1'b1; op = o; rs = a; rt = b;
        tick();
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 100) begin
            bcnt += int'(busy);
            tick();
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), ed ? 64'd1 : 64'(LAT));
        chk({name, "_busy_cycles"}, 64'(bcnt), ed ? 64'd0 : 64'(LAT - 1));
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        chk({name, "_dbz"}, 64'(div_by_zero), 64'(ed));
        m_hi = eh; m_lo = el;
        tick();
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] eh, el;
        logic         ed;
        logic [W-1:0] edge_vals[5];
        int           saw_done;

        reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        m_hi = '0; m_lo = '0;
        edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'hFFFF_FFFF; edge_vals[4] = 32'h7FFF_FFFF;

        vecs.push_back('{"multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{"mult_neg",   2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{"div_sign",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0});
        vecs.push_back('{"divu_basic", 2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
        vecs.push_back('{"mult_min2",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0});
        vecs.push_back('{"div_negdiv", 2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"divu_big",   2'b10, 32'hFFFF_FFFF, 32'd16,        32'hF,         32'h0FFF_FFFF, 1'b0});

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_dbz", 64'(div_by_zero), 0);
        chk("rst_hi", 64'(hi), 0);
        chk("rst_lo", 64'(lo), 0);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);

        // Divide by zero leaves HI/LO untouched
        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1);
        mt_write(1'b1, 1'b1, 32'h5A5A_0001);

        // start/hi_we while busy are ignored
        do_reset();
        start = 1'b1; op = 2'b00; rs = 32'd5; rt = 32'd6;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        start = 1'b1; rs = 32'd2; rt = 32'd2; hi_we = 1'b1; wdata = 32'hAA;
        tick();
        start = 1'b0; hi_we = 1'b0;
        for (int c = 6; c < 34; c++) tick();
        chk("hs_done_at_34", 64'(done), 1);
        chk("hs_lo", 64'(lo), 30);
        chk("hs_hi", 64'(hi), 0);
        tick();
        chk("hs_no_second_done", 64'(done), 0);
        chk("hs_idle", 64'(busy), 0);

        // Reset mid-run discards the operation
        start = 1'b1; op = 2'b00; rs = 32'd5; rt = 32'd6;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        do_reset();
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_hi", 64'(hi), 0);
        chk("mid_rst_lo", 64'(lo), 0);
        saw_done = 0;
        tick();
        saw_done += int'(done);
        run_op("post_rst", 2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tick();
            saw_done += int'(done);
        end
        chk("mid_rst_no_stray_done", 64'(saw_done), 0);

        // Randomized ops and MT writes against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = edge_vals[$urandom_range(0, 4)];
                2:       rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom), 1'($urandom), W'($urandom));
            ref_op(ro, ra, rb, eh, el, ed);
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, eh, el, ed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair next to the single-cycle ALU. Handles MULT, MULTU, DIV and DIVU with an iterative one-bit-per-cycle datapath under a start/busy/done handshake. Also services MTHI/MTLO writes. The pipeline stalls on `busy` and reads results through the `hi`/`lo` outputs for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `rs`  in  WIDTH  multiplicand or dividend.
- `rt`  in  WIDTH  multiplier or divisor.
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in progress; the pipeline must stall MF*/MT*/mul/div.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero`  out  1  valid with `done`; 1 when a divide had `rt == 0`.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **States**
  - IDLE: accepts a start.
  - RUN: WIDTH iterations.
  - FIX: applies signs and writes HI/LO.
- **IDLE**
  - `start=1` with `rt!=0`, or with a multiply:
    - Latch op.
    - Latch operand magnitudes: two's-complement absolute value for MULT/DIV, raw for unsigned ops.
    - Latch result sign flags.
    - Counter := WIDTH; go to RUN.
  - `start=1`, divide, `rt==0`:
    - Stay in IDLE; no iteration.
    - Next cycle: `done=1`, `div_by_zero=1`.
    - HI/LO unchanged.
- **RUN, multiply**
  - Shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **RUN, divide**
  - Restoring division, one quotient bit per cycle.
  - Remainder is WIDTH+1 bits for the trial subtract.
- **RUN exit**
  - Counter decrements each cycle; at 1 go to FIX.
- **FIX**
  - Multiply: negate the 2·WIDTH product if the operand signs differ.
    - HI := product[2W-1:W], LO := product[W-1:0].
  - Divide:
    - LO := quotient, negated if the signs differ.
    - HI := remainder, negated if the dividend was negative (sign follows the dividend, truncating division).
  - Go to IDLE.
- **Arithmetic width rules**
  - All arithmetic is modulo 2^WIDTH per half.
  - DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 with no special case. The magnitude path must treat 0x80000000 as unsigned 2^31.
- **MTHI/MTLO**
  - `hi_we`/`lo_we` write only in IDLE with `start=0`.
  - Ignored while busy, and in the same cycle as an accepted start.
  - `hi_we` and `lo_we` may both be set: both registers take `wdata`.
- `start` while busy is ignored; requests are not queued.
- **Reset** (any cycle, including mid-RUN/FIX):
  - Next state IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
  - Any in-flight operation is discarded.

## Timing
- Start sampled at edge E0. RUN occupies E1..E32 and FIX occurs at E33.
- `busy=1` for the 33 cycles after E0, and 0 in the cycle following E33.
- `done=1` (registered) for exactly the one cycle after E33. HI/LO are valid in that same cycle. The block is back in IDLE and a new `start` is accepted in that cycle.
- Latency: start to done is 34 cycles for every non-zero-divisor op (WIDTH=32). In general it is WIDTH+2.
- Divide by zero: `done` and `div_by_zero` are high in the cycle after E0; `busy` stays 0.
- `div_by_zero` is 0 on every `done` except a divide-by-zero.
- `hi`/`lo` change only at FIX, on an MT write, or on reset. Their reset value is 0.
- `busy`, `done` and `div_by_zero` reset to 0.

## Test plan
- **MULTU**: rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at cycle 0.
  - `busy` for 33 cycles.
  - `done` at cycle 34 with hi=0xFFFFFFFE, lo=0x00000001.
- **MULT**: rs=0xFFFFFFFD (−3), rt=7.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **DIV sign handling**: rs=0xFFFFFFF9 (−7), rt=2.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **DIV overflow wrap**: rs=0x80000000, rt=0xFFFFFFFF.
  - lo=0x80000000, hi=0, `div_by_zero=0`.
- **DIVU by zero**: preload hi=0x11, lo=0x22 via MTHI/MTLO; then DIVU rs=100, rt=0.
  - `done` and `div_by_zero` at cycle 1.
  - hi=0x11, lo=0x22; `busy` never asserted.
- **Handshake and reset**:
  - Start MULTU 5×6. Pulse `start` (MULTU 2×2) and `hi_we` (wdata=0xAA) at cycle 5.
    - Both ignored; `done` at 34 with lo=30, hi=0.
  - Repeat the operation, then assert `reset` at cycle 10.
    - Cycle 11: busy=0, hi=lo=0.
    - `done` never pulses.
    - A new start at cycle 12 completes normally at cycle 46.
